spi_hex_target: RTL and testbench
=================================

SPI_HEX_TARGET -- requirements
Module: spi_hex_target

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 50, system clock frequency in MHz (documentation and assertions only).
REQ-002 SHALL have parameter SCK_MIN_DIV, default 8, minimum clk periods per SPI SCK period for guaranteed operation.
REQ-003 SHALL have port clk, input, 1 bit, single system clock; all logic is in this domain.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port spi_sck, input, 1 bit, SPI clock from the SoC SPI controller (asynchronous to clk).
REQ-006 SHALL have port spi_cs_n, input, 1 bit, active-low chip select (asynchronous).
REQ-007 SHALL have port spi_mosi, input, 1 bit, controller-to-target data.
REQ-008 SHALL have port spi_miso, output, 1 bit, target-to-controller data.
REQ-009 SHALL have port spi_miso_oe, output, 1 bit, MISO drive enable; high only while the target is selected.
REQ-010 SHALL have port hex, output, 56 bits, eight active-low 7-segment digits; digit i is hex[7i+6:7i].
REQ-011 SHALL have port wr_strobe, output, 1 bit, one-clk pulse on each register write.
REQ-012 SHALL have port wr_addr, output, 3 bits, address of the write flagged by wr_strobe.

Function
REQ-013 SHALL pass spi_sck, spi_cs_n and spi_mosi through 2-FF synchronizers, then detect SCK rise and fall edges with one extra register stage.
REQ-014 SHALL implement SPI mode 0: sample MOSI on SCK rising edge, update MISO on SCK falling edge, MSB first.
REQ-015 SHALL use a frame of a command byte followed by one or more data bytes: cmd[7]=1 read, 0 write; cmd[6:3] ignored; cmd[2:0] start address.
REQ-016 SHALL hold eight 8-bit registers: reg[i][3:0] is the hex digit value, reg[i][7] is the blank flag, and reg[i][6:4] is stored but unused.
REQ-017 SHALL use FSM states IDLE, CMD, DATA and DRAIN: IDLE->CMD on CS fall; CMD->DATA after the 8th rising edge; DATA stays in DATA per byte; any state->IDLE on CS rise.
REQ-018 SHALL, on a write, update reg[addr] with the received byte within 3 clk after the 8th rising edge of each data byte, and pulse wr_strobe with wr_addr=addr in the same cycle.
REQ-019 SHALL, on a read, load reg[addr] into the shift register in the cycle after the command byte completes and present its bit 7 on MISO before the next SCK rise; subsequent bits follow on falling edges.
REQ-020 SHALL auto-increment addr after each data byte, wrapping 7->0 (burst of any length).
REQ-021 SHALL, if CS rises mid-byte, discard the partial byte with no write, no wr_strobe, and return to IDLE; completed earlier bytes stay written.
REQ-022 SHALL, on an abort during CMD, change no register.
REQ-023 SHALL drive spi_miso=0 while idle and during the command byte of a read, and spi_miso=0 during all bytes of a write.
REQ-024 SHALL drive spi_miso_oe from the synchronized CS (low in IDLE).
REQ-025 SHALL register hex: digit i equals seg7(reg[i][3:0]) when reg[i][7]=0, otherwise 7'h7f; hex updates 1 clk after the register write.
REQ-026 SHALL, when CS falls and a SCK edge arrives in the same synchronized cycle, reset the bit counter first and count that edge.
REQ-027 SHALL ignore SCK edges while CS is high.
REQ-028 SHALL enter DRAIN on a read command with cmd[6:3]!=0 (reserved): shift out 0x00 and perform no writes until CS rises.

Reset
REQ-029 SHALL, with reset_n low, asynchronously set FSM=IDLE, bit counter=0, all registers=8'h80 (blank), hex=all 7'h7f, spi_miso=0, spi_miso_oe=0, wr_strobe=0, wr_addr=0, and synchronizers to idle levels (sck=0, cs_n=1, mosi=0).
REQ-030 SHALL, when reset is asserted mid-frame, drop the frame; after reset release, the target ignores the bus until the next CS fall.

Structure
REQ-031 SHALL place in package spi_hex_pkg: the FSM state enum, the FRAME_BITS=8 constant, the register reset value 8'h80 and the blank segment code 7'h7f.
REQ-032 SHALL use one sub-module, seg7_decode: combinational mapping from 4 bits to an active-low 7-segment code, instantiated eight times.

Verification
REQ-033 SHALL cover single write: SCK=clk/8, frame 0x03,0x0A -> reg3=0x0A, wr_strobe once with wr_addr=3, hex digit3=seg7(A).
REQ-034 SHALL cover burst wrap: write 0x06,0x01,0x02,0x03 -> reg6=1, reg7=2, reg0=3; three wr_strobe pulses at addresses 6, 7, 0.
REQ-035 SHALL cover read-back: after REQ-033, frame 0x83,0x00 -> MISO returns 0x0A MSB first; no wr_strobe.
REQ-036 SHALL cover abort: write 0x02 then CS rise after 5 data bits -> reg2 stays 0x80, no wr_strobe, FSM in IDLE.
REQ-037 SHALL cover reset: reset_n low mid-burst -> all hex=7'h7f immediately, spi_miso_oe=0; a subsequent frame 0x01,0x05 works normally.
REQ-038 SHALL cover blank flag: write 0x04,0x87 -> hex digit4=7'h7f; then write 0x04,0x07 -> digit4=seg7(7).

Source files
------------

// File: rtl/spi_hex_pkg.sv
// Shared types and constants for the SPI-controlled eight-digit hex display target.
package spi_hex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int         FRAME_BITS = 8;
  localparam logic [7:0] REG_RST    = 8'h80;
  localparam logic [6:0] SEG_BLANK  = 7'h7f;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low 7-segment code, bit order {g,f,e,d,c,b,a}.
module seg7_decode (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7f;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'ha: seg_o = 7'h08;
      4'hb: seg_o = 7'h03;
      4'hc: seg_o = 7'h46;
      4'hd: seg_o = 7'h21;
      4'he: seg_o = 7'h06;
      4'hf: seg_o = 7'h0e;
      default: seg_o = 7'h7f;
    endcase
  end

endmodule

// File: rtl/spi_hex_target.sv
// SPI mode-0 target holding eight digit registers that drive a registered 7-segment bus.
// Frame: command byte (bit7 read, bits2:0 start address) then a burst of data bytes.
module spi_hex_target
  import spi_hex_pkg::*;
#(
  parameter int CLK_MHZ     = 50,
  parameter int SCK_MIN_DIV = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [55:0] hex,
  output logic        wr_strobe,
  output logic [2:0]  wr_addr,
  output state_e      dbg_state
);

  if (SCK_MIN_DIV < 6) begin : g_bad_div
    $error("SCK_MIN_DIV too small for the synchronizer latency");
  end
  if (CLK_MHZ < 1) begin : g_bad_clk
    $error("CLK_MHZ must be positive");
  end

  logic       sck_s1_q, sck_s2_q, sck_s3_q;
  logic       cs_s1_q, cs_s2_q, cs_s3_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic [1:0] warm_q;
  logic       armed_q;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [2:0] addr_q, addr_d;
  logic       read_q, read_d;
  logic       load_q, load_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [2:0] wr_addr_q, wr_addr_d;
  logic       miso_oe_q;
  logic       reg_we;
  logic [7:0] regs_q [8];
  logic [55:0] hex_q, hex_d;

  logic       sck_rise, sck_fall, cs_fall, frame_start;
  logic [7:0] rx_byte;

  assign sck_rise    = sck_s2_q & ~sck_s3_q;
  assign sck_fall    = ~sck_s2_q & sck_s3_q;
  assign cs_fall     = ~cs_s2_q & cs_s3_q;
  // armed_q blocks a frame whose CS fall was hidden by reset.
  assign frame_start = cs_fall & armed_q;
  assign rx_byte     = {rx_q[6:0], mosi_s2_q};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    read_d      = read_q;
    load_d      = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    reg_we      = 1'b0;

    // A falling edge right after a byte boundary keeps bit 7 on MISO.
    if (load_q) begin
      tx_d = regs_q[addr_q];
    end else if (sck_fall && bit_cnt_q != 3'd0) begin
      tx_d = {tx_q[6:0], 1'b0};
    end

    if (cs_s2_q) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      tx_d      = 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_d   = ST_CMD;
            tx_d      = 8'h00;
            bit_cnt_d = sck_rise ? 3'd1 : 3'd0;
            if (sck_rise) rx_d = rx_byte;
          end
        end
        default: begin
          if (sck_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(FRAME_BITS - 1)) begin
              case (state_q)
                ST_CMD: begin
                  addr_d = rx_byte[2:0];
                  read_d = rx_byte[7];
                  if (rx_byte[7] && rx_byte[6:3] != 4'd0) begin
                    state_d = ST_DRAIN;
                  end else begin
                    state_d = ST_DATA;
                    load_d  = rx_byte[7];
                  end
                end
                ST_DATA: begin
                  addr_d = addr_q + 3'd1;
                  if (read_q) begin
                    load_d = 1'b1;
                  end else begin
                    reg_we      = 1'b1;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = addr_q;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_s1_q    <= 1'b0;
      sck_s2_q    <= 1'b0;
      sck_s3_q    <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_s3_q     <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      warm_q      <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      addr_q      <= 3'd0;
      read_q      <= 1'b0;
      load_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 3'd0;
      miso_oe_q   <= 1'b0;
      hex_q       <= {8{SEG_BLANK}};
      for (int i = 0; i < 8; i++) regs_q[i] <= REG_RST;
    end else begin
      sck_s1_q    <= spi_sck;
      sck_s2_q    <= sck_s1_q;
      sck_s3_q    <= sck_s2_q;
      cs_s1_q     <= spi_cs_n;
      cs_s2_q     <= cs_s1_q;
      cs_s3_q     <= cs_s2_q;
      mosi_s1_q   <= spi_mosi;
      mosi_s2_q   <= mosi_s1_q;
      warm_q      <= {warm_q[0], 1'b1};
      armed_q     <= armed_q | (warm_q[1] & cs_s2_q);
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      load_q      <= load_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      miso_oe_q   <= armed_q & ~cs_s2_q;
      hex_q       <= hex_d;
      if (reg_we) regs_q[addr_q] <= rx_byte;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_digit
    logic [6:0] seg;
    seg7_decode u_dec (
      .nibble_i (regs_q[i][3:0]),
      .seg_o    (seg)
    );
    assign hex_d[7*i +: 7] = regs_q[i][7] ? SEG_BLANK : seg;
  end

  // wr_strobe is a valid-only pulse: no ready; wr_addr is meaningful while it is high.
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign spi_miso    = tx_q[7];
  assign spi_miso_oe = miso_oe_q;
  assign hex         = hex_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_hex_target.sv
// Directed bench for spi_hex_target: SPI controller driver tasks plus scoreboard monitors.
module tb_spi_hex_target;
  import spi_hex_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [55:0] hex;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  state_e      dbg_state;

  spi_hex_target #(.CLK_MHZ(50), .SCK_MIN_DIV(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .hex         (hex),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  logic [2:0] exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] rd_obs;
  event       rd_ev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_digit(input int i, input logic [6:0] exp);
    check($sformatf("hex_digit%0d", i), 64'(hex[7*i +: 7]), 64'(exp));
  endtask

  // scoreboard: write strobes
  always @(negedge clk) begin : mon_wr
    logic [2:0] e;
    if (wr_strobe === 1'b1) begin
      strobes++;
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_strobe unexpected actual_addr=%0d required=none", wr_addr);
      end else begin
        e = exp_wr_q.pop_front();
        if (wr_addr !== e) begin
          errors++;
          $display("FAIL wr_addr actual=%0d required=%0d", wr_addr, e);
        end
      end
    end
  end

  // scoreboard: bytes returned on MISO
  always @(rd_ev) begin : mon_rd
    logic [7:0] e;
    checks++;
    if (exp_rd_q.size() == 0) begin
      errors++;
      $display("FAIL rd_byte unexpected actual=%0h required=none", rd_obs);
    end else begin
      e = exp_rd_q.pop_front();
      if (rd_obs !== e) begin
        errors++;
        $display("FAIL rd_byte actual=%0h required=%0h", rd_obs, e);
      end
    end
  end

  // driver tasks (SCK = clk/8, mode 0)
  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 7; b >= 8 - nbits; b--) begin
      spi_mosi = tx[b];
      half();
      rx[b] = spi_miso;
      spi_sck = 1'b1;
      half();
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    half();
  endtask

  task automatic cs_end();
    half();
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic cmd_byte(input logic [7:0] c);
    logic [7:0] r;
    spi_byte(c, 8, r);
  endtask

  task automatic wr_byte(input logic [2:0] exp_addr, input logic [7:0] d);
    logic [7:0] r;
    exp_wr_q.push_back(exp_addr);
    spi_byte(d, 8, r);
  endtask

  task automatic rd_byte(input logic [7:0] exp);
    logic [7:0] r;
    exp_rd_q.push_back(exp);
    spi_byte(8'h00, 8, r);
    rd_obs = r;
    ->rd_ev;
  endtask

  initial begin : stim
    logic [7:0] junk;
    repeat (3) @(negedge clk);
    check("rst_hex", 64'(hex), 64'({8{7'h7f}}));
    check("rst_miso", 64'(spi_miso), 64'd0);
    check("rst_miso_oe", 64'(spi_miso_oe), 64'd0);
    check("rst_wr_strobe", 64'(wr_strobe), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // single write 0x03,0x0A
    cs_begin(); cmd_byte(8'h03); wr_byte(3'd3, 8'h0A); cs_end();
    check_digit(3, 7'h08);
    check_digit(2, 7'h7f);

    // read-back 0x83 -> 0x0A
    cs_begin(); cmd_byte(8'h83);
    check("miso_oe_selected", 64'(spi_miso_oe), 64'd1);
    rd_byte(8'h0A); cs_end();
    check("miso_oe_idle", 64'(spi_miso_oe), 64'd0);

    // burst with address wrap 6,7,0
    cs_begin(); cmd_byte(8'h06);
    wr_byte(3'd6, 8'h01); wr_byte(3'd7, 8'h02); wr_byte(3'd0, 8'h03);
    cs_end();
    check_digit(6, 7'h79);
    check_digit(7, 7'h24);
    check_digit(0, 7'h30);

    // abort after 5 data bits
    cs_begin(); cmd_byte(8'h02); spi_byte(8'h55, 5, junk); cs_end();
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    check_digit(2, 7'h7f);
    cs_begin(); cmd_byte(8'h82); rd_byte(8'h80); cs_end();

    // reserved read command drains zeros even though reg3 holds 0x0A
    cs_begin(); cmd_byte(8'h8B);
    check("drain_state", 64'(dbg_state), 64'(ST_DRAIN));
    rd_byte(8'h00); cs_end();
    check_digit(3, 7'h08);

    // blank flag
    cs_begin(); cmd_byte(8'h04); wr_byte(3'd4, 8'h87); cs_end();
    check_digit(4, 7'h7f);
    cs_begin(); cmd_byte(8'h04); wr_byte(3'd4, 8'h07); cs_end();
    check_digit(4, 7'h78);

    // reset in the middle of a burst
    cs_begin(); cmd_byte(8'h05); wr_byte(3'd5, 8'h0C);
    spi_byte(8'h33, 4, junk);
    check_digit(5, 7'h46);
    reset_n = 1'b0;
    #1;
    check("midrst_hex", 64'(hex), 64'({8{7'h7f}}));
    check("midrst_miso_oe", 64'(spi_miso_oe), 64'd0);
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    cs_begin(); cmd_byte(8'h01); wr_byte(3'd1, 8'h05); cs_end();
    check_digit(1, 7'h12);
    check_digit(5, 7'h7f);
    cs_begin(); cmd_byte(8'h81); rd_byte(8'h05); rd_byte(8'h80); cs_end();

    repeat (4) @(negedge clk);
    check("wr_queue_left", 64'(exp_wr_q.size()), 64'd0);
    check("rd_queue_left", 64'(exp_rd_q.size()), 64'd0);
    check("strobe_total", 64'(strobes), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
